// File: rtl/text_console_writer.sv
// text_console_writer
//   Writer side of the text-mode VRAM. Takes a byte stream (ASCII plus the
//   control codes BS/LF/FF/CR) over a valid/ready handshake and turns it into
//   registered VRAM writes at a tracked cursor. A row advance blanks the new
//   row; a form feed blanks the whole screen. Both clears run one cell per
//   cycle while char_ready is held low.
//   VRAM address layout matches the scan-out side: {row[4:0], column[6:0]}.
//
//   Optional build macro: TEXT_CONSOLE_CLEAR_ON_RESET_EN
//     defined   -> leaving reset starts a full-screen clear (busy resets to 1)
//     undefined -> leaving reset goes straight to IDLE, VRAM untouched
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   char_data      incoming byte
//   char_valid     char_data valid
//   char_ready     byte accepted on this cycle's rising edge if valid
//   vram_we        one-cycle write strobe (registered)
//   vram_address   {row, col} of the write (registered)
//   vram_data      glyph code of the write (registered)
//   cursor_row/col current cursor position
//   busy           clear in progress, always ~char_ready
module text_console_writer #(
    parameter int          DISPLAY_CHAR_WIDTH  = 80,
    parameter int          DISPLAY_CHAR_HEIGHT = 30,
    parameter logic [7:0]  BLANK_CHAR          = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char_data,
    input  logic        char_valid,
    output logic        char_ready,
    output logic        vram_we,
    output logic [11:0] vram_address,
    output logic [7:0]  vram_data,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

    localparam logic [6:0] LAST_COL = 7'(DISPLAY_CHAR_WIDTH - 1);
    localparam logic [4:0] LAST_ROW = 5'(DISPLAY_CHAR_HEIGHT - 1);

`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = CLR_ALL;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t     state, next_state;
    logic [6:0] clr_col;
    logic [4:0] clr_row;

    logic accept;
    logic is_bs, is_lf, is_ff, is_cr, is_print;
    logic at_last_col;
    logic clr_last_col, clr_last_cell;
    logic [4:0] row_adv;

    assign accept   = char_valid & char_ready;
    assign is_bs    = (char_data == 8'h08);
    assign is_lf    = (char_data == 8'h0A);
    assign is_ff    = (char_data == 8'h0C);
    assign is_cr    = (char_data == 8'h0D);
    assign is_print = ~(is_bs | is_lf | is_ff | is_cr);

    assign at_last_col   = (cursor_col == LAST_COL);
    assign row_adv       = (cursor_row == LAST_ROW) ? 5'd0 : cursor_row + 5'd1;
    assign clr_last_col  = (clr_col == LAST_COL);
    assign clr_last_cell = clr_last_col && (clr_row == LAST_ROW);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= next_state;
    end

    // Next state
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_ff)                          next_state = CLR_ALL;
                    else if (is_lf)                     next_state = CLR_ROW;
                    else if (is_print && at_last_col)   next_state = CLR_ROW;
                end
            end
            CLR_ROW: if (clr_last_col)  next_state = IDLE;
            CLR_ALL: if (clr_last_cell) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        char_ready = (state == IDLE);
        busy       = (state != IDLE);
    end

    // Cursor, clear counters and the registered VRAM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_row   <= 5'd0;
            cursor_col   <= 7'd0;
            clr_col      <= 7'd0;
            clr_row      <= 5'd0;
            vram_we      <= 1'b0;
            vram_address <= 12'd0;
            vram_data    <= 8'd0;
        end else begin
            vram_we <= 1'b0;
            case (state)
                IDLE: begin
                    // Counters always start a clear from column/row 0.
                    clr_col <= 7'd0;
                    clr_row <= 5'd0;
                    if (accept) begin
                        if (is_print) begin
                            vram_we      <= 1'b1;
                            vram_address <= {cursor_row, cursor_col};
                            vram_data    <= char_data;
                            if (at_last_col) begin
                                cursor_col <= 7'd0;
                                cursor_row <= row_adv;
                            end else begin
                                cursor_col <= cursor_col + 7'd1;
                            end
                        end else if (is_cr) begin
                            cursor_col <= 7'd0;
                        end else if (is_lf) begin
                            cursor_col <= 7'd0;
                            cursor_row <= row_adv;
                        end else if (is_bs) begin
                            if (cursor_col != 7'd0) begin
                                cursor_col   <= cursor_col - 7'd1;
                                vram_we      <= 1'b1;
                                vram_address <= {cursor_row, cursor_col - 7'd1};
                                vram_data    <= BLANK_CHAR;
                            end
                        end else begin
                            // Form feed: cursor homes now; the clear follows.
                            cursor_col <= 7'd0;
                            cursor_row <= 5'd0;
                        end
                    end
                end
                CLR_ROW: begin
                    // cursor_row already points at the row being blanked.
                    vram_we      <= 1'b1;
                    vram_address <= {cursor_row, clr_col};
                    vram_data    <= BLANK_CHAR;
                    clr_col      <= clr_last_col ? 7'd0 : clr_col + 7'd1;
                end
                CLR_ALL: begin
                    vram_we      <= 1'b1;
                    vram_address <= {clr_row, clr_col};
                    vram_data    <= BLANK_CHAR;
                    if (clr_last_col) begin
                        clr_col <= 7'd0;
                        clr_row <= (clr_row == LAST_ROW) ? 5'd0 : clr_row + 5'd1;
                    end else begin
                        clr_col <= clr_col + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

    localparam int W = 80;
    localparam int H = 30;
    localparam logic [7:0] BLANK = 8'h20;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char_data = 8'd0;
    logic        char_valid = 1'b0;
    logic        char_ready, vram_we, busy;
    logic [11:0] vram_address;
    logic [7:0]  vram_data;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;

    int total = 0;
    int bad   = 0;

    wr_t exp_q[$];
    int  mrow = 0;
    int  mcol = 0;

    always #5 clk = ~clk;

    text_console_writer #(.DISPLAY_CHAR_WIDTH(W), .DISPLAY_CHAR_HEIGHT(H), .BLANK_CHAR(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .char_data(char_data), .char_valid(char_valid),
        .char_ready(char_ready), .vram_we(vram_we), .vram_address(vram_address),
        .vram_data(vram_data), .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
    );

    // ---------------- reference model (screen-level rules) ----------------
    task automatic push_wr(input int r, input int c, input logic [7:0] d);
        wr_t w;
        w.addr = 12'(r * 128 + c);
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic advance_row(output int lows);
        mrow = (mrow + 1) % H;
        for (int c = 0; c < W; c++) push_wr(mrow, c, BLANK);
        lows = W;
    endtask

    task automatic model_accept(input logic [7:0] b, output int lows);
        lows = 0;
        case (b)
            8'h0D: mcol = 0;
            8'h0A: begin mcol = 0; advance_row(lows); end
            8'h08: if (mcol > 0) begin mcol = mcol - 1; push_wr(mrow, mcol, BLANK); end
            8'h0C: begin
                for (int r = 0; r < H; r++)
                    for (int c = 0; c < W; c++) push_wr(r, c, BLANK);
                mrow = 0; mcol = 0; lows = W * H;
            end
            default: begin
                push_wr(mrow, mcol, b);
                if (mcol == W - 1) begin mcol = 0; advance_row(lows); end
                else mcol = mcol + 1;
            end
        endcase
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [7:0] b, input bit wait_clr);
        int lows, exp_lows, guard;
        char_data  = b;
        char_valid = 1'b1;
        guard = 0;
        while (!char_ready && guard < 6000) begin @(negedge clk); guard++; end
        if (!char_ready) check("ready_timeout", 0, 1);
        @(posedge clk);
        model_accept(b, exp_lows);
        #1 char_valid = 1'b0;
        check("cursor_row", int'(cursor_row), mrow);
        check("cursor_col", int'(cursor_col), mcol);
        if (wait_clr) begin
            lows = 0;
            forever begin
                @(negedge clk);
                if (char_ready || lows > 6000) break;
                lows++;
            end
            check("ready_low_cycles", lows, exp_lows);
        end
    endtask

    task automatic send_n(input int n, input logic [7:0] b);
        for (int i = 0; i < n; i++) send(b, 1'b1);
    endtask

    logic [7:0] rb;
    int         pick;

    initial begin
        // Monitor: every DUT write must match the oldest expected write.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    total++;
                    if (busy != !char_ready) begin
                        bad++;
                        $display("FAIL busy: got %0b want %0b", busy, !char_ready);
                    end
                    if (vram_we) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_write: addr %03h data %02h, none expected",
                                     vram_address, vram_data);
                        end else begin
                            wr_t e;
                            e = exp_q.pop_front();
                            if (vram_address != e.addr || vram_data != e.data) begin
                                bad++;
                                $display("FAIL write: got addr %03h data %02h want addr %03h data %02h",
                                         vram_address, vram_data, e.addr, e.data);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        #12;
        check("rst_ready", int'(char_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_we", int'(vram_we), 0);
        check("rst_addr", int'(vram_address), 0);
        check("rst_data", int'(vram_data), 0);
        check("rst_cursor", int'({cursor_row, cursor_col}), 0);
        @(negedge clk) rst_n = 1'b1;

        // Single glyph, then CR and a full row forcing a wrap into row 1
        send(8'h41, 1'b1);
        send(8'h0D, 1'b1);
        for (int i = 0; i < W; i++) send(8'h30 + 8'(i % 40), 1'b1);

        // Backspace at (2,5), then at column 0
        send(8'h0A, 1'b1);
        send_n(5, 8'h61);
        send(8'h08, 1'b1);
        send(8'h0D, 1'b1);
        send(8'h08, 1'b1);

        // Walk to (29,7) and wrap the row with LF
        send_n(27, 8'h0A);
        send_n(7, 8'h7E);
        send(8'h0A, 1'b1);

        // Full-screen clear
        send_n(3, 8'h5A);
        send(8'h0C, 1'b1);

        // Randomized stream, mostly printables
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 199);
            if (pick < 8)       rb = 8'h0A;
            else if (pick < 14) rb = 8'h08;
            else if (pick < 18) rb = 8'h0D;
            else if (pick < 19) rb = 8'h0C;
            else begin
                rb = 8'($urandom_range(0, 255));
                if (rb == 8'h08 || rb == 8'h0A || rb == 8'h0C || rb == 8'h0D) rb = 8'h41;
            end
            send(rb, 1'b1);
        end

        // Reset in the middle of a row clear
        send(8'h0A, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midrst_we", int'(vram_we), 0);
        check("midrst_cursor", int'({cursor_row, cursor_col}), 0);
        exp_q.delete();
        mrow = 0; mcol = 0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_ready", int'(char_ready), 1);
        send(8'h42, 1'b1);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
